// File: rtl/ixc_mev_clk_sched.sv
// ixc_mev_clk_sched: schedules per-domain clock toggles, enables and loop/hold
// controls for the multi-event clock generator, stalling on downstream feedback.
module ixc_mev_clk_sched #(
    parameter int NCLK = 2,
    parameter int DIVW = 8,
    parameter int STPW = 16
) (
    input  logic                 xclk,
    input  logic                 rstn,
    input  logic [NCLK*DIVW-1:0] cfg_half,
    input  logic [NCLK*DIVW-1:0] cfg_phase,
    input  logic [STPW-1:0]      cfg_steps,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 hold_req,
    input  logic                 dn_active,
    input  logic                 dn_busy,
    output logic [NCLK-1:0]      clks,
    output logic [NCLK-1:0]      ens,
    output logic                 loop,
    output logic                 hold,
    output logic                 sched_busy,
    output logic                 step_done,
    output logic [STPW-1:0]      ev_count
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

    state_t                     r_state;
    state_t                     w_state_nx;
    logic [NCLK*DIVW-1:0]       r_half;
    logic [NCLK*DIVW-1:0]       r_phase;
    logic [STPW-1:0]            r_steps;
    logic [NCLK-1:0][DIVW-1:0]  r_cnt;
    logic [NCLK-1:0]            r_clks;
    logic [NCLK-1:0]            r_ens;
    logic                       r_loop;
    logic                       r_hold;
    logic                       r_done;
    logic                       r_stop_pend;
    logic [STPW-1:0]            r_ev;
    logic [NCLK-1:0]            w_tog;
    logic                       w_stall;
    logic                       w_dn;
    logic                       w_event;
    logic [STPW-1:0]            w_ev_inc;
    logic                       w_steps_hit;

    assign w_dn        = dn_active | dn_busy;
    assign w_stall     = hold_req | w_dn;
    assign w_event     = |w_tog;
    assign w_ev_inc    = (&r_ev) ? r_ev : r_ev + 1'b1;
    assign w_steps_hit = (r_steps != '0) && w_event && (w_ev_inc == r_steps);

    always_comb begin
        w_tog = '0;
        for (int i = 0; i < NCLK; i++)
            w_tog[i] = (r_state == S_RUN) && !w_stall && r_ens[i] && (r_cnt[i] == '0);
    end

    // An empty enable set still passes through RUN so the run terminates cleanly.
    always_comb begin
        w_state_nx = (r_state == S_IDLE) ? (start ? S_ARM : S_IDLE) :
                     (r_state == S_ARM)  ? S_RUN :
                     (r_state == S_RUN)  ? ((stop || r_stop_pend || w_steps_hit || ~|r_ens) ? S_DRAIN : S_RUN) :
                     (w_dn ? S_DRAIN : S_IDLE);
    end

    always_ff @(posedge xclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_half      <= '0;
            r_phase     <= '0;
            r_steps     <= '0;
            r_cnt       <= '0;
            r_clks      <= '0;
            r_ens       <= '0;
            r_loop      <= 1'b0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_ev        <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_hold      <= (w_state_nx == S_DRAIN) || ((w_state_nx == S_RUN) && w_stall);
            r_done      <= (r_state == S_DRAIN) && !w_dn;
            r_stop_pend <= (r_state == S_ARM) && stop;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_half  <= cfg_half;
                        r_phase <= cfg_phase;
                        r_steps <= cfg_steps;
                        r_ev    <= '0;
                    end
                end
                S_ARM: begin
                    for (int i = 0; i < NCLK; i++) begin
                        r_cnt[i] <= r_phase[i*DIVW +: DIVW];
                        r_ens[i] <= r_half[i*DIVW +: DIVW] != '0;
                        if (r_half[i*DIVW +: DIVW] == '0)
                            r_clks[i] <= 1'b0;
                    end
                    r_loop <= r_steps == '0;
                end
                S_RUN: begin
                    for (int i = 0; i < NCLK; i++) begin
                        if (!w_stall && r_ens[i]) begin
                            if (w_tog[i]) begin
                                r_clks[i] <= ~r_clks[i];
                                r_cnt[i]  <= r_half[i*DIVW +: DIVW] - 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - 1'b1;
                            end
                        end
                    end
                    if (w_event)
                        r_ev <= w_ev_inc;
                    if (w_state_nx == S_DRAIN) begin
                        r_ens  <= '0;
                        r_loop <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clks       = r_clks;
    assign ens        = r_ens;
    assign loop       = r_loop;
    assign hold       = r_hold;
    assign sched_busy = r_state != S_IDLE;
    assign step_done  = r_done;
    assign ev_count   = r_ev;
endmodule
